// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
//  Module   : hazard_fwd_ctrl
//  Brief    : Load-use stall detection and EX operand forwarding selects for
//             a 5-stage in-order pipeline, tracking EX and MEM stage records.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] C_SEL_EXEC = 2'b00;
    localparam logic [1:0] C_SEL_MEM  = 2'b01;
    localparam logic [1:0] C_SEL_RF   = 2'b10;

    // EX stage record
    logic              ex_valid_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              ex_reg_write_q;
    logic              ex_mem_read_q;

    // MEM stage record
    logic              mem_valid_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_reg_write_q;
    logic              mem_mem_read_q;

    logic [1:0]        fwd_sel_a_q, fwd_sel_a_d;
    logic [1:0]        fwd_sel_b_q, fwd_sel_b_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic w_ex_prod_rs, w_ex_prod_rt;
    logic w_mem_prod_rs, w_mem_prod_rt;
    logic w_load_use;
    logic w_id_live;
    logic w_ex_load;

    // Register r0 is hardwired to zero, so it never carries a hazard.
    function automatic logic produces(input logic              v,
                                      input logic              rw,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
        return v && rw && (rd == r) && (r != '0);
    endfunction

    always_comb begin
        w_ex_prod_rs  = produces(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  id_rs);
        w_ex_prod_rt  = produces(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  id_rt);
        w_mem_prod_rs = produces(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs);
        w_mem_prod_rt = produces(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rt);

        w_id_live  = id_valid && !flush;
        w_load_use = ex_mem_read_q &&
                     ((id_uses_rs && w_ex_prod_rs) || (id_uses_rt && w_ex_prod_rt));
        stall      = !reset && w_id_live && w_load_use;
        w_ex_load  = w_id_live && !stall;
    end

    // Selects are resolved against the records as they stand now, i.e. the
    // producers one and two instructions ahead of the one entering EX.
    always_comb begin
        fwd_sel_a_d = C_SEL_RF;
        fwd_sel_b_d = C_SEL_RF;
        if (w_ex_load && id_uses_rs) begin
            if (w_ex_prod_rs)       fwd_sel_a_d = C_SEL_EXEC;
            else if (w_mem_prod_rs) fwd_sel_a_d = C_SEL_MEM;
        end
        if (w_ex_load && id_uses_rt) begin
            if (w_ex_prod_rt)       fwd_sel_b_d = C_SEL_EXEC;
            else if (w_mem_prod_rt) fwd_sel_b_d = C_SEL_MEM;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            fwd_sel_a_q     <= C_SEL_RF;
            fwd_sel_b_q     <= C_SEL_RF;
            stall_count_q   <= '0;
        end else begin
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_mem_read_q  <= ex_mem_read_q;
            ex_valid_q      <= w_ex_load;
            ex_rd_q         <= id_rd;
            ex_reg_write_q  <= id_reg_write;
            ex_mem_read_q   <= id_mem_read;
            fwd_sel_a_q     <= fwd_sel_a_d;
            fwd_sel_b_q     <= fwd_sel_b_d;
            stall_count_q   <= stall_count_d;
        end
    end

    // The MEM load flag is carried for record completeness only.
    logic w_unused;
    assign w_unused = mem_mem_read_q;

    assign fwd_sel_a   = fwd_sel_a_q;
    assign fwd_sel_b   = fwd_sel_b_q;
    assign ex_valid    = ex_valid_q;
    assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
//  Module   : tb_hazard_fwd_ctrl
//  Brief    : Directed self-checking bench for hazard_fwd_ctrl (CNT_W=2 so
//             saturation is reachable with a handful of load-use pairs).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_uses_rs, id_uses_rt;
    logic              id_reg_write, id_mem_read;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_sel_a, fwd_sel_b;
    logic              ex_valid;
    logic [CNT_W-1:0]  stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .ex_valid     (ex_valid),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rs, input int rt,
                         input logic urs, input logic urt, input int rd,
                         input logic rw, input logic mr, input logic fl);
        id_valid     = v;
        id_rs        = REG_AW'(rs);
        id_rt        = REG_AW'(rt);
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_rd        = REG_AW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // lw r2 then add r7,r2,r2 then a bubble: exactly one stall cycle.
    task automatic load_use_pair();
        drive(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2, 2, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tick();
        chk("rst_sel_a", 32'(fwd_sel_a), 32'h2);
        chk("rst_sel_b", 32'(fwd_sel_b), 32'h2);
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_count", 32'(stall_count), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        reset = 1'b0;

        // add r3,r1,r2 ; add r4,r3,r5
        drive(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        chk("b2b_stall", 32'(stall), 32'h0);
        tick();
        chk("b2b_sel_a", 32'(fwd_sel_a), 32'h0);
        chk("b2b_sel_b", 32'(fwd_sel_b), 32'h2);
        chk("b2b_ex_valid", 32'(ex_valid), 32'h1);

        // add r3 ; nop ; sub r6,r1,r3
        drive(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        chk("nop_ex_valid", 32'(ex_valid), 32'h0);
        drive(1'b1, 1, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
        tick();
        chk("gap_sel_a", 32'(fwd_sel_a), 32'h2);
        chk("gap_sel_b", 32'(fwd_sel_b), 32'h1);

        // lw r2 ; add r7,r2,r2
        drive(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2, 2, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", 32'(stall), 32'h1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_stall_gone", 32'(stall), 32'h0);
        chk("lu_count", 32'(stall_count), 32'h1);
        tick();
        chk("lu_sel_a", 32'(fwd_sel_a), 32'h1);
        chk("lu_sel_b", 32'(fwd_sel_b), 32'h1);
        chk("lu_ex_valid", 32'(ex_valid), 32'h1);
        chk("lu_count_hold", 32'(stall_count), 32'h1);

        // add r0 ; add r1,r0,r0
        drive(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("r0_sel_a", 32'(fwd_sel_a), 32'h2);
        chk("r0_sel_b", 32'(fwd_sel_b), 32'h2);

        // Unused operands never forward even if a match exists.
        drive(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 5, 1'b0, 1'b0, 6, 1'b1, 1'b0, 1'b0);
        tick();
        chk("unused_sel_a", 32'(fwd_sel_a), 32'h2);
        chk("unused_sel_b", 32'(fwd_sel_b), 32'h2);

        // lw r2 ; add r7,r2,r1 with flush
        drive(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2, 1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b1);
        chk("flush_stall", 32'(stall), 32'h0);
        tick();
        chk("flush_ex_valid", 32'(ex_valid), 32'h0);
        chk("flush_sel_a", 32'(fwd_sel_a), 32'h2);
        chk("flush_count", 32'(stall_count), 32'h1);

        // Reset during a pending load-use
        drive(1'b1, 1, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2, 2, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_masks_stall", 32'(stall), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_stall", 32'(stall), 32'h0);
        chk("post_rst_count", 32'(stall_count), 32'h0);
        tick();
        chk("post_rst_ex_valid", 32'(ex_valid), 32'h1);
        chk("post_rst_sel_a", 32'(fwd_sel_a), 32'h2);
        nop();
        tick();

        // Saturation: 2 pairs bring count to all-ones minus 1, then 2 more.
        load_use_pair();
        load_use_pair();
        chk("sat_pre", 32'(stall_count), 32'h2);
        load_use_pair();
        chk("sat_reach", 32'(stall_count), 32'h3);
        load_use_pair();
        chk("sat_hold", 32'(stall_count), 32'h3);
        reset = 1'b1;
        tick();
        chk("sat_reset", 32'(stall_count), 32'h0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
